// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scanner: segment width,
// segment bit positions and the hex-to-segment lookup.
package seven_seg_pkg;

    localparam int SEG_W = 7;

    // Bit positions inside a segment vector {g,f,e,d,c,b,a}
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-high segment pattern for one hex nibble
    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
        logic [SEG_W-1:0] pattern;
        case (nib)
            4'h0:    pattern = 7'h3F;
            4'h1:    pattern = 7'h06;
            4'h2:    pattern = 7'h5B;
            4'h3:    pattern = 7'h4F;
            4'h4:    pattern = 7'h66;
            4'h5:    pattern = 7'h6D;
            4'h6:    pattern = 7'h7D;
            4'h7:    pattern = 7'h07;
            4'h8:    pattern = 7'h7F;
            4'h9:    pattern = 7'h6F;
            4'hA:    pattern = 7'h77;
            4'hB:    pattern = 7'h7C;
            4'hC:    pattern = 7'h39;
            4'hD:    pattern = 7'h5E;
            4'hE:    pattern = 7'h79;
            4'hF:    pattern = 7'h71;
            default: pattern = 7'h00;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seven_seg_hex_decoder.sv
// Combinational hex nibble to active-high segment decoder.
import seven_seg_pkg::*;

module seven_seg_hex_decoder (
    input  logic [3:0]       nib,
    output logic [SEG_W-1:0] seg
);

    // Table lookup; polarity is applied by the caller
    always_comb begin
        seg = hex_to_seg(nib);
    end

endmodule

// File: rtl/seven_seg_scanner_n.sv
// Time-multiplexed common-anode 7-segment scanner with frame snapshot,
// leading-zero blanking, PWM brightness and selectable pin polarity.
// Pipeline: counters (A) -> registered counters (B) -> output regs (C),
// so counter state reaches the pins two cycles later.
import seven_seg_pkg::*;

module seven_seg_scanner_n #(
    parameter int  NUM_DIGITS       = 4,
    parameter int  BRIGHT_W         = 2,
    parameter bit  ANODE_ACTIVE_LOW = 1'b1,
    parameter bit  SEG_ACTIVE_LOW   = 1'b1,
    localparam int SEL_W            = $clog2(NUM_DIGITS)
) (
    input  logic                    div_clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_mask,
    input  logic                    blank_leading,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [SEG_W-1:0]        seg,
    output logic                    dp_out,
    output logic [SEL_W-1:0]        digit_sel,
    output logic                    frame_done
);

    localparam logic [BRIGHT_W-1:0]   DWELL_MAX  = {BRIGHT_W{1'b1}};
    localparam logic [BRIGHT_W-1:0]   DWELL_ZERO = {BRIGHT_W{1'b0}};
    localparam logic [SEL_W-1:0]      IDX_LAST   = SEL_W'(NUM_DIGITS - 1);
    localparam logic [SEL_W-1:0]      IDX_ZERO   = {SEL_W{1'b0}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = ANODE_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [SEG_W-1:0]      SEG_OFF    = SEG_ACTIVE_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
    localparam logic                  DP_OFF     = SEG_ACTIVE_LOW;

    // Stage A counters
    logic [BRIGHT_W-1:0]     dwell_r;
    logic [SEL_W-1:0]        idx_r;
    logic                    load_s;

    // Frame snapshot
    logic [4*NUM_DIGITS-1:0] snap_value_r;
    logic [NUM_DIGITS-1:0]   snap_dp_r;
    logic [NUM_DIGITS-1:0]   snap_mask_r;
    logic [BRIGHT_W-1:0]     snap_bright_r;
    logic [NUM_DIGITS-1:0]   snap_blank_r;
    logic [NUM_DIGITS-1:0]   blank_s;
    logic                    zero_run_s;

    // Stage B
    logic [BRIGHT_W-1:0]     dwell_b_r;
    logic [SEL_W-1:0]        idx_b_r;
    logic                    en_b_r;

    // Stage C next-state
    logic [3:0]              nib_s;
    logic [SEG_W-1:0]        seg_hi_s;
    logic [NUM_DIGITS-1:0]   onehot_s;
    logic                    lit_s;
    logic [NUM_DIGITS-1:0]   an_next_s;
    logic [SEG_W-1:0]        seg_next_s;
    logic                    dp_next_s;
    logic                    fd_next_s;

    assign load_s = enable & (idx_r == IDX_ZERO) & (dwell_r == DWELL_ZERO);

    // Dwell/digit counters; both freeze while enable is low
    always_ff @(posedge div_clock or posedge reset) begin
        if (reset) begin
            dwell_r <= DWELL_ZERO;
            idx_r   <= IDX_ZERO;
        end else if (enable) begin
            if (dwell_r == DWELL_MAX) begin
                dwell_r <= DWELL_ZERO;
                idx_r   <= (idx_r == IDX_LAST) ? IDX_ZERO : idx_r + SEL_W'(1);
            end else begin
                dwell_r <= dwell_r + BRIGHT_W'(1);
            end
        end
    end

    // Leading-zero blank vector: a digit blanks only if it and every digit above it are zero
    always_comb begin
        zero_run_s = 1'b1;
        blank_s    = {NUM_DIGITS{1'b0}};
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run_s = zero_run_s & (value[4*k +: 4] == 4'h0);
            blank_s[k] = blank_leading & zero_run_s;
        end
    end

    // Capture all display inputs once per frame so a frame is always coherent
    always_ff @(posedge div_clock or posedge reset) begin
        if (reset) begin
            snap_value_r  <= {(4*NUM_DIGITS){1'b0}};
            snap_dp_r     <= {NUM_DIGITS{1'b0}};
            snap_mask_r   <= {NUM_DIGITS{1'b0}};
            snap_bright_r <= {BRIGHT_W{1'b0}};
            snap_blank_r  <= {NUM_DIGITS{1'b0}};
        end else if (load_s) begin
            snap_value_r  <= value;
            snap_dp_r     <= dp;
            snap_mask_r   <= digit_mask;
            snap_bright_r <= brightness;
            snap_blank_r  <= blank_s;
        end
    end

    // Stage B: counter state aligned with the snapshot it will be shown with
    always_ff @(posedge div_clock or posedge reset) begin
        if (reset) begin
            dwell_b_r <= DWELL_ZERO;
            idx_b_r   <= IDX_ZERO;
            en_b_r    <= 1'b0;
        end else begin
            dwell_b_r <= dwell_r;
            idx_b_r   <= idx_r;
            en_b_r    <= enable;
        end
    end

    assign nib_s = snap_value_r[{idx_b_r, 2'b00} +: 4];

    seven_seg_hex_decoder u_decoder (
        .nib (nib_s),
        .seg (seg_hi_s)
    );

    // Next pin values: one digit lit during its PWM on-time, everything dark otherwise
    always_comb begin
        onehot_s = {NUM_DIGITS{1'b0}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            onehot_s[k] = (idx_b_r == SEL_W'(k));
        end
        lit_s = en_b_r & snap_mask_r[idx_b_r] & ~snap_blank_r[idx_b_r]
              & (dwell_b_r <= snap_bright_r);
        if (lit_s) begin
            an_next_s  = ANODE_ACTIVE_LOW ? ~onehot_s : onehot_s;
            seg_next_s = SEG_ACTIVE_LOW ? ~seg_hi_s : seg_hi_s;
            dp_next_s  = SEG_ACTIVE_LOW ? ~snap_dp_r[idx_b_r] : snap_dp_r[idx_b_r];
        end else begin
            an_next_s  = AN_OFF;
            seg_next_s = SEG_OFF;
            dp_next_s  = DP_OFF;
        end
        fd_next_s = en_b_r & (idx_b_r == IDX_LAST) & (dwell_b_r == DWELL_MAX);
    end

    // Stage C: registered pin drivers
    always_ff @(posedge div_clock or posedge reset) begin
        if (reset) begin
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp_out     <= DP_OFF;
            digit_sel  <= IDX_ZERO;
            frame_done <= 1'b0;
        end else begin
            an         <= an_next_s;
            seg        <= seg_next_s;
            dp_out     <= dp_next_s;
            digit_sel  <= idx_b_r;
            frame_done <= fd_next_s;
        end
    end

endmodule
